// File: rtl/spike_cls_pkg.sv
// Shared types and helpers for the spike-count readout stage.
// Optional CLASS_TIE_REJECT_EN is handled in spike_count_classifier.
package spike_cls_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      SCAN,
      DONE
   } cls_state_t;

   // Index width that stays legal for a single neuron.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// One per-neuron spike counter that sticks at all-ones.
// Clear wins over increment so a new window starts from zero.
module spike_sat_counter
   import spike_cls_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] value_o
);

   logic [CNT_W-1:0] val_q;
   logic [CNT_W-1:0] val_d;

   // Next value: clear, saturating increment or hold.
   always_comb begin
      val_d = val_q;
      if (clr_i) begin
         val_d = '0;
      end else if (inc_i && (val_q != {CNT_W{1'b1}})) begin
         val_d = val_q + 1'b1;
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         val_q <= '0;
      end else begin
         val_q <= val_d;
      end
   end

   assign value_o = val_q;

endmodule

// File: rtl/spike_count_classifier.sv
// Counts output-neuron spikes over a window, then scans for the arg-max.
// Define CLASS_TIE_REJECT_EN to report ties on the maximum as no-winner.
module spike_count_classifier
   import spike_cls_pkg::*;
#(
   parameter int OUT_NUM    = 6,
   parameter int WINDOW     = 150,
   parameter int CNT_W      = 8,
   parameter int MIN_SPIKES = 1
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      EN,
   input  logic                      START,
   input  logic [OUT_NUM-1:0]        SPIKES,
   output logic                      BUSY,
   output logic                      LABEL_VALID,
   output logic [idx_w(OUT_NUM)-1:0] LABEL,
   output logic [CNT_W-1:0]          COUNT_MAX,
   output logic                      NO_WIN
);

   localparam int IW = idx_w(OUT_NUM);
   localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(OUT_NUM - 1);
   localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_SPIKES);

   cls_state_t       state_q;
   logic [7:0]       win_q;
   logic [IW-1:0]    idx_q;
   logic [CNT_W-1:0] max_q;
   logic [IW-1:0]    arg_q;
   logic             busy_q;
   logic             lv_q;
   logic [IW-1:0]    label_q;
   logic [CNT_W-1:0] cmax_q;
   logic             nowin_q;

   logic             start_acc;
   logic             acc_en;
   logic [CNT_W-1:0] cnt [OUT_NUM];
   logic [CNT_W-1:0] cur;
   logic [CNT_W-1:0] max_d;
   logic [IW-1:0]    arg_d;
   logic             nowin_d;

   assign start_acc = START &&
                      ((state_q == IDLE) || (state_q == DONE));
   assign acc_en = (state_q == ACCUM) && EN;

   for (genvar k = 0; k < OUT_NUM; k++) begin : g_cnt
      spike_sat_counter #(
         .CNT_W(CNT_W)
      ) u_cnt (
         .CLK    (CLK),
         .RST    (RST),
         .clr_i  (start_acc),
         .inc_i  (acc_en && SPIKES[k]),
         .value_o(cnt[k])
      );
   end

   // Running arg-max step; the first neuron seeds the maximum.
   always_comb begin
      cur   = cnt[idx_q];
      max_d = max_q;
      arg_d = arg_q;
      if ((idx_q == '0) || (cur > max_q)) begin
         max_d = cur;
         arg_d = idx_q;
      end
   end

`ifdef CLASS_TIE_REJECT_EN
   logic tie_q;
   logic tie_d;

   // Tie flag: set on equal count, dropped when the maximum moves.
   always_comb begin
      tie_d = tie_q;
      if ((idx_q == '0) || (cur > max_q)) begin
         tie_d = 1'b0;
      end else if (cur == max_q) begin
         tie_d = 1'b1;
      end
   end

   // Tie flag register, only advanced while scanning.
   always_ff @(posedge CLK) begin
      if (RST) begin
         tie_q <= 1'b0;
      end else if (state_q == SCAN) begin
         tie_q <= tie_d;
      end
   end

   assign nowin_d = (max_d < MIN_C) || tie_d;
`else
   assign nowin_d = (max_d < MIN_C);
`endif

   // Control FSM with window/scan counters and registered results.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         win_q   <= '0;
         idx_q   <= '0;
         max_q   <= '0;
         arg_q   <= '0;
         busy_q  <= 1'b0;
         lv_q    <= 1'b0;
         label_q <= '0;
         cmax_q  <= '0;
         nowin_q <= 1'b0;
      end else begin
         lv_q <= 1'b0;
         unique case (state_q)
            IDLE, DONE: begin
               if (START) begin
                  state_q <= ACCUM;
                  win_q   <= '0;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ACCUM: begin
               if (EN) begin
                  win_q <= win_q + 8'd1;
                  if (win_q == WIN_LAST) begin
                     state_q <= SCAN;
                     idx_q   <= '0;
                  end
               end
            end
            SCAN: begin
               max_q <= max_d;
               arg_q <= arg_d;
               idx_q <= idx_q + 1'b1;
               if (idx_q == IDX_LAST) begin
                  state_q <= DONE;
                  lv_q    <= 1'b1;
                  cmax_q  <= max_d;
                  nowin_q <= nowin_d;
                  label_q <= nowin_d ? '0 : arg_d;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign BUSY        = busy_q;
   assign LABEL_VALID = lv_q;
   assign LABEL       = label_q;
   assign COUNT_MAX   = cmax_q;
   assign NO_WIN      = nowin_q;

endmodule
